// File: rtl/alu_pkg.sv
// Shared constants and entry payload for the ALU result stage.
//   WIDTH          : adder datapath width
//   FLAG_*         : bit positions inside the 4-bit {N,Z,C,V} flag field
//   alu_entry_t    : one buffered {result, flags} entry
//   pack_flags()   : assembles the flag field from individual bits
package alu_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned FLAG_N   = 3;
    localparam int unsigned FLAG_Z   = 2;
    localparam int unsigned FLAG_C   = 1;
    localparam int unsigned FLAG_V   = 0;
    localparam int unsigned STICKY_W = 2;
    localparam int unsigned OVF_W    = 8;
    localparam int unsigned OCC_W    = 4;

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [FLAG_W-1:0] flags;
    } alu_entry_t;

    // Place each flag at its architectural bit position.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                     input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Entry buffer for the ALU result stage: storage, wrapping pointers, occupancy.
//   Clk, Reset    : clock, synchronous active-high reset
//   i_push        : request to write i_entry (ignored when full)
//   i_entry       : entry to write
//   i_pop         : request to retire the head (ignored when empty)
//   o_in_ready    : space available (registered-state only)
//   o_out_valid   : head entry present
//   o_head        : head entry, all zero when empty
//   o_count       : number of stored entries
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_push,
    input  alu_entry_t       i_entry,
    input  logic             i_pop,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output alu_entry_t       o_head,
    output logic [OCC_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    alu_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        o_in_ready  = (r_count < OCC_W'(DEPTH));
        o_out_valid = (r_count != '0);
        o_head      = o_out_valid ? r_mem[r_rd_ptr] : '0;
        o_count     = r_count;
        w_do_push   = i_push && o_in_ready;
        w_do_pop    = i_pop && o_out_valid;
    end

    // Storage is not reset; the head is masked whenever occupancy is zero.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers adder results with {N,Z,C,V} flags and keeps
// sticky carry/overflow flags plus a saturating overflow counter.
//   Clk, Reset                     : clock, synchronous active-high reset
//   InValid/InReady                : upstream handshake
//   ResultC, CarryOut, Overflow,
//   Negative                       : adder sum and flags
//   OutValid/OutReady              : downstream handshake
//   OutData, OutFlags              : head result and {N,Z,C,V}, zero when empty
//   StickyFlags                    : sticky {C,V}
//   ClearSticky                    : clears StickyFlags and OvfCount
//   OvfCount                       : saturating count of accepted V=1 entries
//   Occupancy                      : stored entry count
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WIDTH-1:0]    ResultC,
    input  logic                CarryOut,
    input  logic                Overflow,
    input  logic                Negative,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WIDTH-1:0]    OutData,
    output logic [FLAG_W-1:0]   OutFlags,
    output logic [STICKY_W-1:0] StickyFlags,
    input  logic                ClearSticky,
    output logic [OVF_W-1:0]    OvfCount,
    output logic [OCC_W-1:0]    Occupancy
);

    localparam int unsigned DP_W    = alu_pkg::WIDTH;
    localparam int unsigned STK_C   = 1;
    localparam int unsigned STK_V   = 0;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    alu_entry_t            w_in_entry;
    alu_entry_t            w_head;
    logic                  w_push;
    logic                  w_pop;
    logic [STICKY_W-1:0]   r_sticky;
    logic [OVF_W-1:0]      r_ovf_cnt;

    // Z is resolved at capture so the buffer carries a complete flag set.
    always_comb begin
        w_in_entry.result = DP_W'(ResultC);
        w_in_entry.flags  = pack_flags(Negative, (ResultC == '0), CarryOut, Overflow);
        w_push            = InValid && InReady;
        w_pop             = OutValid && OutReady;
    end

    alu_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_push      (InValid),
        .i_entry     (w_in_entry),
        .i_pop       (OutReady),
        .o_in_ready  (InReady),
        .o_out_valid (OutValid),
        .o_head      (w_head),
        .o_count     (Occupancy)
    );

    always_comb begin
        OutData     = WIDTH'(w_head.result);
        OutFlags    = w_head.flags;
        StickyFlags = r_sticky;
        OvfCount    = r_ovf_cnt;
    end

    // Sticky bits: a setting acceptance beats a concurrent clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sticky <= '0;
        end else begin
            if (w_push && CarryOut) begin
                r_sticky[STK_C] <= 1'b1;
            end else if (ClearSticky) begin
                r_sticky[STK_C] <= 1'b0;
            end
            if (w_push && Overflow) begin
                r_sticky[STK_V] <= 1'b1;
            end else if (ClearSticky) begin
                r_sticky[STK_V] <= 1'b0;
            end
        end
    end

    // Overflow counter saturates; clear plus a counted acceptance restarts at 1.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf_cnt <= '0;
        end else if (w_push && Overflow) begin
            if (ClearSticky) begin
                r_ovf_cnt <= OVF_W'(1);
            end else if (r_ovf_cnt != OVF_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
            end
        end else if (ClearSticky) begin
            r_ovf_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int DEPTH = 2;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] ResultC;
    logic        CarryOut;
    logic        Overflow;
    logic        Negative;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic [3:0]  OutFlags;
    logic [1:0]  StickyFlags;
    logic        ClearSticky;
    logic [7:0]  OvfCount;
    logic [3:0]  Occupancy;

    alu_result_stage #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .ResultC     (ResultC),
        .CarryOut    (CarryOut),
        .Overflow    (Overflow),
        .Negative    (Negative),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutData     (OutData),
        .OutFlags    (OutFlags),
        .StickyFlags (StickyFlags),
        .ClearSticky (ClearSticky),
        .OvfCount    (OvfCount),
        .Occupancy   (Occupancy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an ordered list of {data, flags} plus sticky state.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
    } ent_t;

    ent_t m_q[$];
    logic [1:0] m_sticky = 2'b00;
    int         m_ovf    = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] res;
        logic        n;
        logic        c;
        logic        v;
        logic        ordy;
        logic        clr;
        logic [3:0]  occ;
        logic        ovld;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [1:0]  sticky;
        logic [7:0]  ovf;
        logic        irdy;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare DUT to model.
    task automatic cycle(input logic rst, input logic iv, input logic [31:0] res,
                         input logic n, input logic c, input logic v,
                         input logic ordy, input logic clr);
        bit acc;
        bit pop;
        ent_t e;
        Reset = rst; InValid = iv; ResultC = res; Negative = n; CarryOut = c;
        Overflow = v; OutReady = ordy; ClearSticky = clr;
        @(posedge Clk);
        if (rst) begin
            m_q.delete();
            m_sticky = 2'b00;
            m_ovf    = 0;
        end else begin
            acc = iv && (m_q.size() < DEPTH);
            pop = ordy && (m_q.size() != 0);
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                e.data  = res;
                e.flags = {n, (res == 32'd0), c, v};
                m_q.push_back(e);
            end
            if (acc && c) m_sticky[1] = 1'b1; else if (clr) m_sticky[1] = 1'b0;
            if (acc && v) m_sticky[0] = 1'b1; else if (clr) m_sticky[0] = 1'b0;
            if (acc && v) m_ovf = clr ? 1 : ((m_ovf < 255) ? m_ovf + 1 : 255);
            else if (clr) m_ovf = 0;
        end
        #1;
        chk("model_occupancy", 64'(Occupancy), 64'(m_q.size()));
        chk("model_in_ready", 64'(InReady), 64'(m_q.size() < DEPTH));
        chk("model_out_valid", 64'(OutValid), 64'(m_q.size() != 0));
        chk("model_out_data", 64'(OutData), (m_q.size() != 0) ? 64'(m_q[0].data) : 64'd0);
        chk("model_out_flags", 64'(OutFlags), (m_q.size() != 0) ? 64'(m_q[0].flags) : 64'd0);
        chk("model_sticky", 64'(StickyFlags), 64'(m_sticky));
        chk("model_ovf_count", 64'(OvfCount), 64'(m_ovf));
    endtask

    function automatic vec_t mk(input logic rst, input logic iv, input logic [31:0] res,
                                input logic n, input logic c, input logic v,
                                input logic ordy, input logic clr,
                                input logic [3:0] occ, input logic ovld,
                                input logic [31:0] data, input logic [3:0] flags,
                                input logic [1:0] sticky, input logic [7:0] ovf,
                                input logic irdy);
        vec_t t;
        t.rst = rst; t.iv = iv; t.res = res; t.n = n; t.c = c; t.v = v;
        t.ordy = ordy; t.clr = clr; t.occ = occ; t.ovld = ovld; t.data = data;
        t.flags = flags; t.sticky = sticky; t.ovf = ovf; t.irdy = irdy;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        Reset = 1'b1; InValid = 1'b0; ResultC = 32'd0; Negative = 1'b0;
        CarryOut = 1'b0; Overflow = 1'b0; OutReady = 1'b0; ClearSticky = 1'b0;

        //             rst   iv    res           n     c     v     ordy  clr   | occ   ovld  data          flags    stk    ovf    irdy
        tbl.push_back(mk(1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,32'h0,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0, 4'd1,1'b1,32'h0,        4'b0110,2'b10,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0, 4'd0,1'b0,32'h0,        4'b0000,2'b10,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h80000000, 1'b1,1'b0,1'b1,1'b0,1'b0, 4'd1,1'b1,32'h80000000, 4'b1001,2'b11,8'd1,1'b1));
        tbl.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1, 4'd0,1'b0,32'h0,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h1,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,32'h1,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h2,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd2,1'b1,32'h1,        4'b0000,2'b00,8'd0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,32'h3,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd2,1'b1,32'h1,        4'b0000,2'b00,8'd0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0, 4'd1,1'b1,32'h2,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0, 4'd0,1'b0,32'h0,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h7,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,32'h7,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h5,        1'b0,1'b0,1'b0,1'b1,1'b0, 4'd1,1'b1,32'h5,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,32'h5,        4'b0000,2'b00,8'd0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,32'h9,        1'b0,1'b1,1'b0,1'b0,1'b0, 4'd2,1'b1,32'h5,        4'b0000,2'b10,8'd0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,32'hA,        1'b0,1'b0,1'b0,1'b1,1'b0, 4'd0,1'b0,32'h0,        4'b0000,2'b00,8'd0,1'b1));

        // Directed vectors, each checked against its own expected row.
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            cycle(t.rst, t.iv, t.res, t.n, t.c, t.v, t.ordy, t.clr);
            chk($sformatf("vec%0d_occupancy", i), 64'(Occupancy), 64'(t.occ));
            chk($sformatf("vec%0d_out_valid", i), 64'(OutValid), 64'(t.ovld));
            chk($sformatf("vec%0d_out_data", i), 64'(OutData), 64'(t.data));
            chk($sformatf("vec%0d_out_flags", i), 64'(OutFlags), 64'(t.flags));
            chk($sformatf("vec%0d_sticky", i), 64'(StickyFlags), 64'(t.sticky));
            chk($sformatf("vec%0d_ovf_count", i), 64'(OvfCount), 64'(t.ovf));
            chk($sformatf("vec%0d_in_ready", i), 64'(InReady), 64'(t.irdy));
        end

        // Overflow counter saturation, then clear coinciding with a counted push.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("ovf_saturated", 64'(OvfCount), 64'd255);
        cycle(1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ovf_clear_with_push", 64'(OvfCount), 64'd1);
        chk("sticky_v_clear_with_push", 64'(StickyFlags[0]), 64'd1);
        chk("sticky_c_cleared", 64'(StickyFlags[1]), 64'd0);

        // Head holds while the consumer stalls.
        cycle(1'b0, 1'b1, 32'hCAFE0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_data", 64'(OutData), 64'hCAFE0000);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_flags", 64'(OutFlags), 64'b1010);

        // Randomized traffic against the model.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), r,
                  r[31], 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
